// File: rtl/vgg16_bram_responder.sv
// vgg16_bram_responder
// Memory-side end of the shared vgg16_bram port. Layer engines get fixed
// one-cycle BRAM read timing with priority. A valid/ready host port preloads
// images and reads results back while no engine owns the memory.
// Addresses at or beyond DEPTH are never stored. They read as zero and set a
// sticky error flag that only reset clears.

module vgg16_bram_responder #(
    parameter int DATA_SIZE  = 8,
    parameter int ADDR_WIDTH = 20,
    parameter int DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vgg16_bram_ena,
    input  logic                  vgg16_bram_wea,
    input  logic [ADDR_WIDTH-1:0] vgg16_bram_addra,
    input  logic [DATA_SIZE-1:0]  vgg16_bram_dina,
    output logic [DATA_SIZE-1:0]  vgg16_bram_douta,
    input  logic                  engine_busy,
    input  logic                  host_req_valid,
    output logic                  host_req_ready,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_SIZE-1:0]  host_wdata,
    output logic                  host_rsp_valid,
    output logic [DATA_SIZE-1:0]  host_rsp_data,
    output logic                  addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [0:0] {
        H_IDLE = 1'b0,
        H_RSP  = 1'b1
    } host_state_t;

    // True when the word address maps onto an implemented memory word.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < DEPTH_W);
    endfunction

    logic [DATA_SIZE-1:0] mem_r [0:DEPTH-1];

    host_state_t          state_r;
    logic [DATA_SIZE-1:0] douta_r;
    logic                 ready_r;
    logic                 rsp_valid_r;
    logic [DATA_SIZE-1:0] rsp_data_r;
    logic                 addr_err_r;

    logic                 eng_in_range_s;
    logic                 host_in_range_s;
    logic                 eng_rd_s;
    logic                 eng_wr_s;
    logic                 host_accept_s;
    logic [IDX_W-1:0]     eng_idx_s;
    logic [IDX_W-1:0]     host_idx_s;
    logic [DATA_SIZE-1:0] eng_rd_data_s;
    logic [DATA_SIZE-1:0] host_rd_data_s;
    logic                 mem_we_s;
    logic [IDX_W-1:0]     mem_widx_s;
    logic [DATA_SIZE-1:0] mem_wdata_s;
    logic                 ready_next_s;

    assign eng_idx_s  = vgg16_bram_addra[IDX_W-1:0];
    assign host_idx_s = host_addr[IDX_W-1:0];

    // Decode both ports: range checks, read data, host accept and the write mux.
    // The engine always wins the single write port; the registered ready keeps
    // the host off the memory in any cycle where the engine could be active.
    always_comb begin
        eng_in_range_s  = addr_in_range(vgg16_bram_addra);
        host_in_range_s = addr_in_range(host_addr);
        eng_rd_s        = vgg16_bram_ena && !vgg16_bram_wea;
        eng_wr_s        = vgg16_bram_ena && vgg16_bram_wea;
        host_accept_s   = (state_r == H_IDLE) && ready_r && host_req_valid;
        eng_rd_data_s   = {DATA_SIZE{1'b0}};
        host_rd_data_s  = {DATA_SIZE{1'b0}};
        mem_we_s        = 1'b0;
        mem_widx_s      = {IDX_W{1'b0}};
        mem_wdata_s     = {DATA_SIZE{1'b0}};
        ready_next_s    = 1'b0;

        if (eng_in_range_s) begin
            eng_rd_data_s = mem_r[eng_idx_s];
        end else begin
            eng_rd_data_s = {DATA_SIZE{1'b0}};
        end

        if (host_in_range_s) begin
            host_rd_data_s = mem_r[host_idx_s];
        end else begin
            host_rd_data_s = {DATA_SIZE{1'b0}};
        end

        if (eng_wr_s) begin
            if (eng_in_range_s) begin
                mem_we_s    = 1'b1;
                mem_widx_s  = eng_idx_s;
                mem_wdata_s = vgg16_bram_dina;
            end else begin
                mem_we_s    = 1'b0;
            end
        end else if (host_accept_s && host_we && host_in_range_s) begin
            mem_we_s    = 1'b1;
            mem_widx_s  = host_idx_s;
            mem_wdata_s = host_wdata;
        end else begin
            mem_we_s    = 1'b0;
        end

        // Ready may only rise when the FSM will be idle after this edge.
        if ((state_r == H_IDLE) && !host_accept_s) begin
            ready_next_s = !engine_busy && !vgg16_bram_ena;
        end else if (state_r == H_RSP) begin
            ready_next_s = !engine_busy && !vgg16_bram_ena;
        end else begin
            ready_next_s = 1'b0;
        end
    end

    // Storage write; contents survive reset, but nothing is written while in reset.
    always_ff @(posedge clk) begin
        if (rst && mem_we_s) begin
            mem_r[mem_widx_s] <= mem_wdata_s;
        end
    end

    // Engine read data register: loads on engine reads only, holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            douta_r <= {DATA_SIZE{1'b0}};
        end else if (eng_rd_s) begin
            douta_r <= eng_rd_data_s;
        end else begin
            douta_r <= douta_r;
        end
    end

    // Host FSM: accept in H_IDLE, deliver a one-cycle response from H_RSP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= H_IDLE;
            ready_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {DATA_SIZE{1'b0}};
        end else begin
            ready_r <= ready_next_s;
            case (state_r)
                H_IDLE: begin
                    if (host_accept_s) begin
                        state_r     <= H_RSP;
                        rsp_valid_r <= 1'b1;
                        rsp_data_r  <= host_we ? {DATA_SIZE{1'b0}} : host_rd_data_s;
                    end else begin
                        state_r     <= H_IDLE;
                        rsp_valid_r <= 1'b0;
                        rsp_data_r  <= {DATA_SIZE{1'b0}};
                    end
                end
                H_RSP: begin
                    state_r     <= H_IDLE;
                    rsp_valid_r <= 1'b0;
                    rsp_data_r  <= {DATA_SIZE{1'b0}};
                end
                default: begin
                    state_r     <= H_IDLE;
                    rsp_valid_r <= 1'b0;
                    rsp_data_r  <= {DATA_SIZE{1'b0}};
                end
            endcase
        end
    end

    // Sticky out-of-range flag, set by an access from either port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_err_r <= 1'b0;
        end else if ((vgg16_bram_ena && !eng_in_range_s) ||
                     (host_accept_s && !host_in_range_s)) begin
            addr_err_r <= 1'b1;
        end else begin
            addr_err_r <= addr_err_r;
        end
    end

    assign vgg16_bram_douta = douta_r;
    assign host_req_ready   = ready_r;
    assign host_rsp_valid   = rsp_valid_r;
    assign host_rsp_data    = rsp_data_r;
    assign addr_err         = addr_err_r;

endmodule

// File: tb/tb_vgg16_bram_responder.sv
// Directed and randomized bench for vgg16_bram_responder. The reference model
// is a plain word array plus the expected engine read register and error flag.

module tb_vgg16_bram_responder;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        wea;
    logic [19:0] addra;
    logic [7:0]  dina;
    logic [7:0]  douta;
    logic        busy;
    logic        hvalid;
    logic        hready;
    logic        hwe;
    logic [19:0] haddr;
    logic [7:0]  hwdata;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        addr_err;

    logic [7:0]  ref_mem [0:4095];
    logic [7:0]  exp_douta;
    logic        exp_err;
    int          pass_cnt;
    int          fail_cnt;
    int          total_cnt;
    int          cyc;
    int          rsp_cyc;

    vgg16_bram_responder #(
        .DATA_SIZE (8),
        .ADDR_WIDTH(20),
        .DEPTH     (4096)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .vgg16_bram_ena  (ena),
        .vgg16_bram_wea  (wea),
        .vgg16_bram_addra(addra),
        .vgg16_bram_dina (dina),
        .vgg16_bram_douta(douta),
        .engine_busy     (busy),
        .host_req_valid  (hvalid),
        .host_req_ready  (hready),
        .host_we         (hwe),
        .host_addr       (haddr),
        .host_wdata      (hwdata),
        .host_rsp_valid  (rsp_valid),
        .host_rsp_data   (rsp_data),
        .addr_err        (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_douta"}, 32'(douta), 32'd0);
        check({tag, "_ready"}, 32'(hready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_addr_err"}, 32'(addr_err), 32'd0);
    endtask

    function automatic logic [19:0] rand_addr();
        logic [19:0] a;
        if ($urandom_range(0, 9) == 0) begin
            a = 20'(4096 + $urandom_range(0, 2000));
        end else begin
            a = 20'($urandom_range(0, 63));
        end
        return a;
    endfunction

    // One engine cycle: drive, advance the model, check douta and addr_err.
    task automatic eng_cycle(input logic en, input logic we, input logic [19:0] a, input logic [7:0] d);
        ena   = en;
        wea   = we;
        addra = a;
        dina  = d;
        if (en) begin
            if (a < 20'd4096) begin
                if (we) ref_mem[a] = d;
                else    exp_douta  = ref_mem[a];
            end else begin
                exp_err = 1'b1;
                if (!we) exp_douta = 8'h00;
            end
        end
        step();
        check("eng_douta", 32'(douta), 32'(exp_douta));
        check("eng_addr_err", 32'(addr_err), 32'(exp_err));
    endtask

    // One host transaction: wait (bounded) for ready, then check the pulse.
    task automatic host_op(input logic we, input logic [19:0] a, input logic [7:0] wd, output logic [7:0] rd);
        logic [7:0] exp_data;
        int         waited;
        hvalid = 1'b1;
        hwe    = we;
        haddr  = a;
        hwdata = wd;
        waited = 0;
        while (hready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        check("host_ready_wait", 32'(hready), 32'd1);
        if (a < 20'd4096) begin
            exp_data = we ? 8'h00 : ref_mem[a];
            if (we) ref_mem[a] = wd;
        end else begin
            exp_data = 8'h00;
            exp_err  = 1'b1;
        end
        step();
        hvalid  = 1'b0;
        rsp_cyc = cyc;
        rd      = rsp_data;
        check("host_rsp_valid", 32'(rsp_valid), 32'd1);
        check("host_rsp_data", 32'(rsp_data), 32'(exp_data));
        check("host_addr_err", 32'(addr_err), 32'(exp_err));
        step();
        check("host_rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] preload [0:2];
        logic [7:0] pool_v [0:3];
        int         prev_cyc;

        pass_cnt = 0; fail_cnt = 0; total_cnt = 0; cyc = 0; rsp_cyc = 0;
        exp_douta = 8'h00; exp_err = 1'b0;
        preload[0] = 8'h11; preload[1] = 8'h22; preload[2] = 8'h33;
        pool_v[0] = 8'd5; pool_v[1] = 8'd9; pool_v[2] = 8'd7; pool_v[3] = 8'd2;

        // Reset with both ports active: every output must stay 0.
        rst = 1'b0; busy = 1'b0;
        ena = 1'b1; wea = 1'b1; addra = 20'd0; dina = 8'hEE;
        hvalid = 1'b1; hwe = 1'b1; haddr = 20'd1; hwdata = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all_zero("reset");
        end
        rst = 1'b1; ena = 1'b0; wea = 1'b0; hvalid = 1'b0;
        step();
        check("ready_after_reset", 32'(hready), 32'd1);

        // Host preload and readback, responses two cycles apart.
        prev_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            host_op(1'b1, 20'(i), preload[i], rd);
            if (i > 0) check("host_wr_spacing", 32'(rsp_cyc - prev_cyc), 32'd2);
            prev_cyc = rsp_cyc;
        end
        for (int i = 0; i < 3; i++) begin
            host_op(1'b0, 20'(i), 8'h00, rd);
            check("host_readback", 32'(rd), 32'(preload[i]));
            check("host_rd_spacing", 32'(rsp_cyc - prev_cyc), 32'd2);
            prev_cyc = rsp_cyc;
        end

        // Pool-style engine read of address 12.
        for (int i = 0; i < 4; i++) host_op(1'b1, 20'(10 + i), pool_v[i], rd);
        busy = 1'b1;
        step();
        check("pool_ready_busy", 32'(hready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            eng_cycle(1'b1, 1'b0, 20'd12, 8'h00);
            check("pool_douta", 32'(douta), 32'd7);
            check("pool_ready", 32'(hready), 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            eng_cycle(1'b0, 1'b0, 20'd0, 8'h00);
            check("pool_douta_hold", 32'(douta), 32'd7);
            check("pool_ready_hold", 32'(hready), 32'd0);
        end

        // Engine write then read of address 100.
        eng_cycle(1'b1, 1'b1, 20'd100, 8'hA5);
        check("wr_no_writethrough", 32'(douta), 32'd7);
        eng_cycle(1'b1, 1'b0, 20'd100, 8'h00);
        check("raw_douta", 32'(douta), 32'hA5);

        // Out-of-range accesses.
        eng_cycle(1'b1, 1'b1, 20'd4096, 8'h5A);
        check("oor_addr_err", 32'(addr_err), 32'd1);
        eng_cycle(1'b1, 1'b0, 20'd0, 8'h00);
        check("oor_addr0_kept", 32'(douta), 32'h11);
        eng_cycle(1'b0, 1'b0, 20'd0, 8'h00);
        busy = 1'b0;
        step();
        host_op(1'b0, 20'hFFFFF, 8'h00, rd);
        check("oor_host_rdata", 32'(rd), 32'd0);
        check("oor_err_sticky", 32'(addr_err), 32'd1);

        // Contention: host request held while busy and an ena pulse block it.
        busy = 1'b1;
        step();
        check("cont_ready_busy0", 32'(hready), 32'd0);
        hvalid = 1'b1; hwe = 1'b1; haddr = 20'd200; hwdata = 8'h3C;
        for (int i = 0; i < 2; i++) begin
            step();
            check("cont_ready_busy", 32'(hready), 32'd0);
            check("cont_no_rsp_busy", 32'(rsp_valid), 32'd0);
        end
        busy = 1'b0;
        eng_cycle(1'b1, 1'b0, 20'd10, 8'h00);
        check("cont_ready_ena", 32'(hready), 32'd0);
        check("cont_no_rsp_ena", 32'(rsp_valid), 32'd0);
        eng_cycle(1'b0, 1'b0, 20'd0, 8'h00);
        check("cont_ready_rise", 32'(hready), 32'd1);
        check("cont_no_rsp_lag", 32'(rsp_valid), 32'd0);
        step();
        hvalid = 1'b0;
        ref_mem[200] = 8'h3C;
        check("cont_rsp", 32'(rsp_valid), 32'd1);
        check("cont_rsp_data", 32'(rsp_data), 32'd0);
        step();
        check("cont_rsp_once", 32'(rsp_valid), 32'd0);
        check("cont_ready_back", 32'(hready), 32'd1);
        step();
        check("cont_rsp_once2", 32'(rsp_valid), 32'd0);
        host_op(1'b0, 20'd200, 8'h00, rd);
        check("cont_write_landed", 32'(rd), 32'h3C);

        // Second reset: writes dropped, addr_err cleared, contents kept.
        rst = 1'b0;
        ena = 1'b1; wea = 1'b1; addra = 20'd100; dina = 8'hEE;
        hvalid = 1'b1; hwe = 1'b1; haddr = 20'd100; hwdata = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all_zero("reset2");
        end
        rst = 1'b1; ena = 1'b0; wea = 1'b0; hvalid = 1'b0; busy = 1'b0;
        exp_douta = 8'h00; exp_err = 1'b0;
        step();
        check("ready_after_reset2", 32'(hready), 32'd1);
        check("err_cleared", 32'(addr_err), 32'd0);
        busy = 1'b1;
        eng_cycle(1'b1, 1'b0, 20'd100, 8'h00);
        check("reset_no_write", 32'(douta), 32'hA5);

        // Randomized phase: fill 0..63, then mixed engine bursts and host ops.
        for (int i = 0; i < 64; i++) eng_cycle(1'b1, 1'b1, 20'(i), 8'($urandom));
        for (int blk = 0; blk < 25; blk++) begin
            busy = 1'b1;
            for (int j = 0; j < 8; j++) begin
                eng_cycle(1'($urandom), 1'($urandom), rand_addr(), 8'($urandom));
                check("rand_ready_busy", 32'(hready), 32'd0);
            end
            eng_cycle(1'b0, 1'b0, 20'd0, 8'h00);
            busy = 1'b0;
            step();
            for (int k = 0; k < 3; k++) begin
                host_op(1'($urandom), rand_addr(), 8'($urandom), rd);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/vgg16_bram_responder.md
# vgg16_bram_responder

Memory-side responder for the shared `vgg16_bram` port driven by the layer engines (conv, pool, fc). It holds the feature-map/result storage, answers engine reads and writes with fixed one-cycle BRAM timing, and provides a valid/ready host port for preloading input images and reading back results while no engine is running. An engine drives `vgg16_bram_ena`, `vgg16_bram_wea`, `vgg16_bram_addra` and `vgg16_bram_dina`, and samples `vgg16_bram_douta`. This block is the other end of that port.

## Interface
- `DATA_SIZE`, default 8: word width in bits.
- `ADDR_WIDTH`, default 20: address width on both ports.
- `DEPTH`, default 4096: number of implemented words; valid addresses are 0..DEPTH-1.
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-low reset (0 = reset).
- `vgg16_bram_ena` input 1: engine access enable.
- `vgg16_bram_wea` input 1: engine write enable; it is qualified by `ena`.
- `vgg16_bram_addra` input ADDR_WIDTH: engine word address.
- `vgg16_bram_dina` input DATA_SIZE: engine write data.
- `vgg16_bram_douta` output DATA_SIZE: engine read data, registered.
- `engine_busy` input 1: a layer engine owns memory; the host port is blocked.
- `host_req_valid` input 1: host request valid.
- `host_req_ready` output 1: the host request is accepted when valid and ready are both 1 at an edge.
- `host_we` input 1: 1 = write, 0 = read.
- `host_addr` input ADDR_WIDTH: host word address.
- `host_wdata` input DATA_SIZE: host write data.
- `host_rsp_valid` output 1: one-cycle response pulse for every accepted host request.
- `host_rsp_data` output DATA_SIZE: read data; 0 for a write acknowledge.
- `addr_err` output 1: sticky flag; set by any access, from either port, with address >= DEPTH.

## Operation
- Reset (`rst`=0 at an edge) sets every output to 0:
  - `vgg16_bram_douta`, `host_req_ready`, `host_rsp_valid`, `host_rsp_data` and `addr_err` all go to 0.
  - Memory contents are not cleared.
  - Reset during a host transaction drops the transaction; no response is issued.
- Engine port (always has priority):
  - Read: `ena`=1 and `wea`=0 at edge E loads `douta` with mem[addra] at edge E.
  - Write: `ena`=1 and `wea`=1 at edge E writes mem[addra]=dina at edge E. `douta` keeps its old value (no write-through).
  - `ena`=0: memory is untouched and `douta` holds its last value indefinitely.
  - Holding `ena` with the same address for several cycles re-reads the same word; this is harmless.
- Host port, two-state FSM:
  - H_IDLE: `host_req_ready` = !engine_busy && !vgg16_bram_ena, registered as described under Timing. On accept, the request is performed at the accept edge (write commits, or read data is captured) and the FSM goes to H_RSP; ready drops to 0.
  - H_RSP: `host_rsp_valid`=1 for exactly one cycle with `host_rsp_data` set. The FSM returns to H_IDLE. There is only one outstanding request.
  - If `engine_busy` rises while in H_RSP, the response is still delivered; no further requests are accepted.
- Address range:
  - An address >= DEPTH, on either port, sets `addr_err`.
  - An out-of-range write is dropped.
  - An out-of-range read returns 0: `douta`=0, or `host_rsp_data`=0.
  - `addr_err` clears only on reset.
- Collision: both ports in the same cycle cannot occur. `host_req_ready` is 0 whenever the engine `ena` was 1 in the previous cycle or `engine_busy` is 1. A host request that is held stalls and has no effect.

## Timing
- Engine read latency is 1 edge from the request being sampled to `douta`. An engine that asserts `ena`/`addra` at edge N and samples `douta` at edge N+2 or later always sees the requested word.
- Engine read-after-write to the same address, issued in the next cycle, returns the new data.
- `host_req_ready` is a register, updated each edge to !engine_busy && !vgg16_bram_ena && (next state == H_IDLE). This gives one cycle of lag after the engine releases the port.
- Host accept at edge A gives `host_rsp_valid`=1 in the cycle after A; it falls at edge A+1. The next accept is possible at edge A+2 at the earliest.
- Throughput:
  - Engine port: 1 access per cycle.
  - Host port: 1 access per 2 cycles.

## Test plan
- Reset: drive `rst`=0 for 3 cycles while applying `ena`=1 and `host_req_valid`=1. Required: all outputs are 0 throughout, and nothing is written. Then release with `engine_busy`=0 and `ena`=0. Required: `host_req_ready`=1 one edge after release.
- Host preload and readback: host writes 0x11, 0x22, 0x33 to addresses 0..2, then reads addresses 0..2. Required: a `host_rsp_valid` pulse for each request, 2 cycles apart; read data is 0x11, 0x22, 0x33.
- Pool-style engine read:
  - Preload addresses 10..13 with 5, 9, 7, 2.
  - Raise `engine_busy`; the engine drives `ena`=1 and addr=12 for 3 cycles.
  - Required: `douta`=7 one edge after the request is sampled, and it holds 7 after `ena` drops.
  - Required: `host_req_ready`=0 throughout.
- Engine write then read: write 0xA5 to address 100; read address 100 in the next cycle. Required: `douta`=0xA5. During the write cycle itself, `douta` is unchanged.
- Out of range:
  - Engine write of 0x5A to address 4096: required `addr_err`=1, and address 0 is unchanged.
  - Host read of address 0xFFFFF: required `host_rsp_data`=0.
  - `addr_err` stays 1 until reset.
- Contention: hold `host_req_valid`=1 while `engine_busy` toggles 1→0 and `ena` pulses.
  - Required: no accept while `engine_busy`=1, nor in the cycle after any `ena`=1.
  - Required: the accept lands on the first allowed edge, with exactly one response.
